// File: rtl/commit_reporter.sv
// Commit record producer: buffers retired instructions, tags MMIO accesses and
// non-deterministic CSR reads, and emits at most one record per cycle to the sink.
module commit_reporter #(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] MMIO_BASE   = 32'ha0000000,
    parameter logic [31:0] MMIO_MASK   = 32'hf0000000,
    parameter int          HANG_CYCLES = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        in_mem_en,
    input  logic [31:0] in_mem_addr,
    input  logic        in_csr_en,
    input  logic [11:0] in_csr_id,
    input  logic        drain_en,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_is_mmio,
    output logic [11:0] out_rcsr_id,
    output logic [63:0] commit_cnt,
    output logic        hang
);

    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(HANG_CYCLES + 1);
    localparam logic [PW:0]   PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDLE_ONE = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] HANG_MAX = IW'(HANG_CYCLES);

    // CSRs whose read value differs between core and reference model.
    function automatic logic is_nd_csr(input logic [11:0] id);
        case (id)
            12'hB00, 12'hB02, 12'hC00, 12'hC01, 12'hC02, 12'h344: is_nd_csr = 1'b1;
            default:                                              is_nd_csr = 1'b0;
        endcase
    endfunction

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic        mmio_mem [DEPTH];
    logic [11:0] rcsr_mem [DEPTH];

    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [31:0]   out_inst_q, out_inst_d;
    logic          out_is_mmio_q, out_is_mmio_d;
    logic [11:0]   out_rcsr_id_q, out_rcsr_id_d;
    logic [63:0]   commit_cnt_q, commit_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          hang_q, hang_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          enq_mmio;
    logic [11:0]   enq_rcsr;

    assign wr_idx = wr_ptr_q[PW-1:0];
    assign rd_idx = rd_ptr_q[PW-1:0];
    assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr_q == rd_ptr_q);

    // in_ready deliberately ignores a same-cycle pop to keep it a pure register decode.
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && drain_en;

    assign enq_mmio = in_mem_en && ((in_mem_addr & MMIO_MASK) == MMIO_BASE);
    assign enq_rcsr = (in_csr_en && is_nd_csr(in_csr_id)) ? in_csr_id : 12'h000;

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_idx]   <= in_pc;
            inst_mem[wr_idx] <= in_inst;
            mmio_mem[wr_idx] <= enq_mmio;
            rcsr_mem[wr_idx] <= enq_rcsr;
        end
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        out_valid_d   = 1'b0;
        out_pc_d      = 32'h0;
        out_inst_d    = 32'h0;
        out_is_mmio_d = 1'b0;
        out_rcsr_id_d = 12'h000;
        commit_cnt_d  = commit_cnt_q;
        idle_d        = idle_q;
        hang_d        = hang_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + PTR_ONE;
            out_valid_d   = 1'b1;
            out_pc_d      = pc_mem[rd_idx];
            out_inst_d    = inst_mem[rd_idx];
            out_is_mmio_d = mmio_mem[rd_idx];
            out_rcsr_id_d = rcsr_mem[rd_idx];
        end

        if (out_valid_q) begin
            commit_cnt_d = commit_cnt_q + 64'd1;
        end

        // A paused sink is not a hang, so drain_en=0 restarts the idle window.
        if (out_valid_q || !drain_en) begin
            idle_d = '0;
        end else if (idle_q != HANG_MAX) begin
            idle_d = idle_q + IDLE_ONE;
        end
        if (idle_d == HANG_MAX) begin
            hang_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'h0;
            out_inst_q    <= 32'h0;
            out_is_mmio_q <= 1'b0;
            out_rcsr_id_q <= 12'h000;
            commit_cnt_q  <= 64'h0;
            idle_q        <= '0;
            hang_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_inst_q    <= out_inst_d;
            out_is_mmio_q <= out_is_mmio_d;
            out_rcsr_id_q <= out_rcsr_id_d;
            commit_cnt_q  <= commit_cnt_d;
            idle_q        <= idle_d;
            hang_q        <= hang_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_inst    = out_inst_q;
    assign out_is_mmio = out_is_mmio_q;
    assign out_rcsr_id = out_rcsr_id_q;
    assign commit_cnt  = commit_cnt_q;
    assign hang        = hang_q;

endmodule
